neg_unit: RTL and testbench

NEG_UNIT -- requirements
Module: neg_unit

---
 rtl/neg_unit.sv | 111 +++++++++++
 tb/tb_neg_unit.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/neg_unit.sv
// neg_unit: multi-cycle pass / negate / absolute-value unit.
// Each cycle it processes one CHUNK-bit slice of the operand, from the LSB
// slice upward, and carries the ripple carry from one slice to the next.
// Optional build macro NEG_UNIT_SAT_EN: an overflow result (negating the
// most-negative value) saturates to the maximum positive value instead of
// wrapping. ovf is raised in both builds.
module neg_unit #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [1:0]       mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] c,
   output logic             ovf
);

   localparam int NCH = WIDTH / CHUNK;
   localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`ifdef NEG_UNIT_SAT_EN
   localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
`endif

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_q;      // latched operand
   logic [WIDTH-1:0] res_q;    // result register, drives c directly
   logic             inv_q;    // mode is reduced to a single invert flag at accept
   logic             carry_q;
   logic [KW-1:0]    k_q;      // current chunk index
   logic             ovf_q;

   logic             acc_inv;
   logic             last;
   logic             is_ovf;
   logic [CHUNK-1:0] a_ch;
   logic [CHUNK:0]   sum;

   // Slice arithmetic for the current chunk: the conditional one's
   // complement plus the carry gives two's-complement negation over all chunks.
   always_comb begin
      acc_inv = (mode == 2'b01) || ((mode == 2'b10) && a[WIDTH-1]);
      last    = (k_q == KW'(NCH-1));
      is_ovf  = inv_q && (a_q == MIN_NEG);
      a_ch    = a_q[k_q*CHUNK +: CHUNK];
      sum     = {1'b0, (inv_q ? ~a_ch : a_ch)} + {{CHUNK{1'b0}}, carry_q};
   end

   // State register; reset aborts any operation that is in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic. Leaving DONE always goes to IDLE, so an operand is
   // never accepted in the same cycle that a result is consumed.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)  state_nxt = BUSY;
         BUSY:    if (last)      state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   // Datapath: capture at accept, then one chunk per cycle while BUSY.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         res_q   <= '0;
         inv_q   <= 1'b0;
         carry_q <= 1'b0;
         k_q     <= '0;
         ovf_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               a_q     <= a;
               inv_q   <= acc_inv;
               carry_q <= acc_inv;
               k_q     <= '0;
               ovf_q   <= 1'b0;
            end
            BUSY: begin
               res_q[k_q*CHUNK +: CHUNK] <= sum[CHUNK-1:0];
               carry_q <= sum[CHUNK];
               k_q     <= last ? '0 : k_q + 1'b1;
               if (last) ovf_q <= is_ovf;
`ifdef NEG_UNIT_SAT_EN
               if (last && is_ovf) res_q <= MAX_POS;
`endif
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign c         = res_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_neg_unit.sv
// Self-checking bench for neg_unit (WIDTH=16, CHUNK=4): directed cases
// followed by random operations checked against an arithmetic reference.
module tb_neg_unit;

   localparam int W = 16;
   localparam int C = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [1:0]   mode = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] c;
   logic         ovf;

   int compared = 0;
   int mismatched = 0;

   neg_unit #(.WIDTH(W), .CHUNK(C)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
      .c(c), .ovf(ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: plain two's-complement arithmetic on the whole operand.
   task automatic model(input logic [W-1:0] av, input logic [1:0] mv,
                        output logic [W-1:0] ec, output logic eo);
      int sv;
      int r;
      sv = av[W-1] ? int'(av) - (1 << W) : int'(av);
      case (mv)
         2'b01:   r = -sv;
         2'b10:   r = (sv < 0) ? -sv : sv;
         default: r = sv;
      endcase
      eo = (r > (1 << (W-1)) - 1);
      ec = r[W-1:0];
`ifdef NEG_UNIT_SAT_EN
      if (eo) ec = W'((1 << (W-1)) - 1);
`endif
   endtask

   // Present one operand in IDLE (called #1 after a rising edge), wait for
   // the result with a bounded wait, check it, then consume it.
   task automatic run_op(input string tag, input logic [W-1:0] av, input logic [1:0] mv);
      logic [W-1:0] ec;
      logic eo;
      int lat;
      model(av, mv, ec, eo);
      chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1; a = av; mode = mv;
      @(posedge clk); #1;
      in_valid = 1'b0; a = W'($urandom); mode = 2'($urandom);
      chk({tag, ".busy_ready"}, 32'(in_ready), 32'd0);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, ".latency"}, 32'(lat), 32'(W / C));
      chk({tag, ".c"}, 32'(c), 32'(ec));
      chk({tag, ".ovf"}, 32'(ovf), 32'(eo));
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, ".idle"}, {31'd0, out_valid}, 32'd0);
   endtask

   initial begin
      logic [W-1:0] hc;
      logic         ho;
      logic [W-1:0] ra;
      int           wd;

      // Reset state
      #12;
      chk("rst.out_valid", 32'(out_valid), 32'd0);
      chk("rst.c", 32'(c), 32'd0);
      chk("rst.ovf", 32'(ovf), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst.in_ready", 32'(in_ready), 32'd1);

      // Directed cases
      run_op("neg1", 16'h0001, 2'b01);
      run_op("absneg", 16'hFF9C, 2'b10);
      run_op("abspos", 16'h0064, 2'b10);
      run_op("pass", 16'h1234, 2'b00);
      run_op("mode3", 16'h8001, 2'b11);
      run_op("neg0", 16'h0000, 2'b01);
      run_op("negmin", 16'h8000, 2'b01);
      run_op("absmin", 16'h8000, 2'b10);
      run_op("passmin", 16'h8000, 2'b00);

      // Hold in DONE with out_ready low; new operands must be ignored.
      in_valid = 1'b1; a = 16'h00F0; mode = 2'b01;
      @(posedge clk); #1;
      in_valid = 1'b0;
      wd = 0;
      while (!out_valid && wd < 20) begin
         @(posedge clk); #1;
         wd++;
      end
      chk("hold.latency", 32'(wd), 32'd4);
      hc = c; ho = ovf;
      chk("hold.c0", 32'(hc), 32'h0000FF10);
      in_valid = 1'b1; a = 16'h0005; mode = 2'b01;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk("hold.valid", 32'(out_valid), 32'd1);
         chk("hold.ready", 32'(in_ready), 32'd0);
         chk("hold.c", 32'(c), 32'(hc));
         chk("hold.ovf", 32'(ovf), 32'(ho));
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("rel.valid", 32'(out_valid), 32'd0);
      chk("rel.no_accept", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk("rel.still_idle", 32'(in_ready), 32'd1);

      // Reset in the middle of an operation
      in_valid = 1'b1; a = 16'h1234; mode = 2'b01;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("abort.valid", 32'(out_valid), 32'd0);
      chk("abort.c", 32'(c), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         chk("abort.no_result", 32'(out_valid), 32'd0);
         chk("abort.c_zero", 32'(c), 32'd0);
      end
      run_op("after_rst", 16'h0002, 2'b01);

      // Random operations
      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 7))
            0:       ra = 16'h8000;
            1:       ra = 16'h0000;
            2:       ra = 16'hFFFF;
            default: ra = W'($urandom);
         endcase
         run_op("rand", ra, 2'($urandom_range(0, 3)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
